// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R1W RAM with byte-masked writes, optional write-to-read bypass and a clear sequencer.
// Latency: re in cycle N, ore in N+1, dout valid after edge N+1; clear takes DEPTH cycles.
// Backpressure: none; busy high while clearing, during which re/we/clr_req are ignored.
module nv_ram_rwsp_param #(
    parameter int              DW           = 256,
    parameter int              DEPTH        = 16,
    parameter int              AW           = $clog2(DEPTH),
    parameter bit              BYPASS       = 1'b1,
    parameter bit              CLR_ON_RESET = 1'b1,
    parameter logic [DW-1:0]   CLR_VAL      = {DW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra,
    input  logic              re,
    input  logic              ore,
    output logic [DW-1:0]     dout,
    output logic              dout_vld,
    input  logic [AW-1:0]     wa,
    input  logic              we,
    input  logic [DW/8-1:0]   wmask,
    input  logic [DW-1:0]     di,
    input  logic              clr_req,
    output logic              busy,
    input  logic [31:0]       pwrbus_ram_pd
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam state_t        RST_STATE = CLR_ON_RESET ? ST_CLEAR : ST_READY;
    localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          ra_vld_q, ra_vld_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;

    logic          wa_ok, ra_ok;
    logic [DW-1:0] rd_word, wa_word, merged, rd_fwd;
    logic          bypass_hit, clr_wr, mem_we;

    logic          unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;

    // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign wa_ok = 1'b1;
        assign ra_ok = 1'b1;
    end else begin : g_npow2
        assign wa_ok = (32'(wa) < DEPTH);
        assign ra_ok = (32'(rd_addr_q) < DEPTH);
    end

    assign rd_word = ra_ok ? mem[rd_addr_q] : CLR_VAL;
    assign wa_word = wa_ok ? mem[wa] : CLR_VAL;

    always_comb begin
        merged = wa_word;
        for (int i = 0; i < DW/8; i++) begin
            if (wmask[i]) begin
                merged[8*i +: 8] = di[8*i +: 8];
            end
        end
    end

    assign bypass_hit = BYPASS && (state_q == ST_READY) && we && wa_ok && (wa == rd_addr_q);
    assign rd_fwd     = bypass_hit ? merged : rd_word;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        ra_vld_d   = ra_vld_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        clr_wr     = 1'b0;
        mem_we     = 1'b0;

        if (ore) begin
            dout_d     = rd_fwd;
            dout_vld_d = ra_vld_q;
        end

        case (state_q)
            ST_CLEAR: begin
                clr_wr = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                mem_we = we && wa_ok;
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    ra_vld_d   = 1'b0;
                    dout_vld_d = 1'b0;
                end else if (re) begin
                    rd_addr_d = ra;
                    ra_vld_d  = 1'b1;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            ra_vld_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            ra_vld_q   <= ra_vld_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    // Array has no reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt_q] <= CLR_VAL;
        end else if (mem_we) begin
            mem[wa] <= merged;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Bench for nv_ram_rwsp_param: BYPASS=1 and BYPASS=0 instances share stimulus and are
// compared every cycle against a word-array reference model, plus directed scenario checks.
module tb_nv_ram_rwsp_param;

    localparam int DW = 64;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra = '0, wa = '0;
    logic          re = 1'b0, ore = 1'b0, we = 1'b0, clr_req = 1'b0;
    logic [DW/8-1:0] wmask = '0;
    logic [DW-1:0] di = '0;
    logic [31:0]   pwr = '0;
    logic [DW-1:0] dout_b, dout_n;
    logic          vld_b, vld_n, busy_b, busy_n;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [AW-1:0] ra_m;
    logic          rav_m, vld_m;
    logic [DW-1:0] db_m, dn_m;
    int            clr_m;

    always #5 clk = ~clk;

    nv_ram_rwsp_param #(.DW(DW), .DEPTH(DEPTH), .BYPASS(1'b1), .CLR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req), .busy(busy_b),
        .pwrbus_ram_pd(pwr));

    nv_ram_rwsp_param #(.DW(DW), .DEPTH(DEPTH), .BYPASS(1'b0), .CLR_ON_RESET(1'b1)) dut_n (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_n), .dout_vld(vld_n),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req), .busy(busy_n),
        .pwrbus_ram_pd(pwr));

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] nw,
                                                 input logic [DW/8-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < DW/8; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_edge();
        logic [DW-1:0] old, mg;
        if (rst) begin
            ra_m = '0; rav_m = 1'b0; vld_m = 1'b0; db_m = '0; dn_m = '0; clr_m = DEPTH;
            return;
        end
        old = mem_m[ra_m];
        if (clr_m > 0) begin
            if (ore) begin db_m = old; dn_m = old; vld_m = 1'b0; end
            mem_m[DEPTH - clr_m] = '0;
            clr_m--;
        end else begin
            mg = apply_mask(mem_m[wa], di, wmask);
            if (ore) begin
                dn_m  = old;
                db_m  = (we && wa == ra_m) ? mg : old;
                vld_m = rav_m;
            end
            if (we) mem_m[wa] = mg;
            if (clr_req) begin
                clr_m = DEPTH; rav_m = 1'b0; vld_m = 1'b0;
            end else if (re) begin
                ra_m = ra; rav_m = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("dout_byp", dout_b, db_m);
        chk("dout_nobyp", dout_n, dn_m);
        chk("vld_byp", {63'b0, vld_b}, {63'b0, vld_m});
        chk("vld_nobyp", {63'b0, vld_n}, {63'b0, vld_m});
        chk("busy_byp", {63'b0, busy_b}, {63'b0, (clr_m > 0)});
        chk("busy_nobyp", {63'b0, busy_n}, {63'b0, (clr_m > 0)});
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_b && n < 100) begin cyc(); n++; end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        we = 1'b1; wa = a; di = d; wmask = m;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        re = 1'b1; ra = a; ore = 1'b0;
        cyc();
        re = 1'b0; ore = 1'b1;
        cyc();
        ore = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        cyc();
        cyc();
        chk("rst_dout", dout_b, '0);
        chk("rst_busy", {63'b0, busy_b}, 64'd1);
        rst = 1'b0;
        count_busy(n);
        chk("clr_len_reset", 64'(n), 64'(DEPTH));

        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a));
            chk("clr_word", dout_b, '0);
        end
        chk("clr_vld", {63'b0, vld_b}, 64'd1);

        // read latency
        wr(4'd3, {8{8'hA5}}, '1);
        re = 1'b1; ra = 4'd3;
        cyc();
        re = 1'b0; ore = 1'b1;
        chk("lat_before", dout_b, '0);
        cyc();
        ore = 1'b0;
        chk("lat_after", dout_b, {8{8'hA5}});

        // byte mask
        wr(4'd5, {8{8'h11}}, '1);
        wr(4'd5, {8{8'hFF}}, 8'h03);
        rd(4'd5);
        chk("bytemask", dout_b, 64'h1111_1111_1111_FFFF);

        // collision
        wr(4'd7, '0, '1);
        rd(4'd7);
        we = 1'b1; wa = 4'd7; di = 64'h1234; wmask = '1; ore = 1'b1;
        cyc();
        we = 1'b0;
        chk("coll_byp", dout_b, 64'h1234);
        chk("coll_nobyp", dout_n, 64'h0);
        cyc();
        ore = 1'b0;
        chk("coll_nobyp_next", dout_n, 64'h1234);

        // clear request mid-traffic, with traffic ignored while busy
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        chk("clrreq_vld", {63'b0, vld_b}, 64'd0);
        n = 0;
        while (busy_b && n < 100) begin
            we = 1'b1; wa = AW'($urandom); di = {$urandom, $urandom}; wmask = '1;
            re = 1'b1; ra = AW'($urandom); ore = 1'($urandom);
            cyc();
            n++;
        end
        we = 1'b0; re = 1'b0; ore = 1'b0;
        chk("clr_len_req", 64'(n), 64'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a));
            chk("clrreq_word", dout_b, '0);
        end

        // randomized traffic with occasional clears
        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom); wa = AW'($urandom); di = {$urandom, $urandom};
            wmask = 8'($urandom);
            re = 1'($urandom); ra = AW'($urandom); ore = 1'($urandom);
            clr_req = ($urandom_range(0, 49) == 0);
            cyc();
        end
        we = 1'b0; re = 1'b0; ore = 1'b0; clr_req = 1'b0;
        count_busy(n);

        // reset mid-clear
        rd(4'd3);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        rst = 1'b1;
        #1;
        chk("rstmid_dout", dout_b, '0);
        chk("rstmid_vld", {63'b0, vld_b}, 64'd0);
        cyc();
        rst = 1'b0;
        count_busy(n);
        chk("clr_len_rstmid", 64'(n), 64'(DEPTH));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsp_param.md
# nv_ram_rwsp_param

Parametrised two-port (one read, one write) synchronous RAM model for FPGA builds: the successor to the fixed-size rwsp macros. It keeps the registered-read-address plus output-register pipeline and adds configurable width and depth, per-byte write masking, and optional write-to-read collision bypass. It also adds a counter-driven memory-clear sequencer that runs after reset or on request and raises `busy` while it runs. Used wherever NVDLA buffers instantiate `nv_ram_rwsp_*` macros.

## Interface
- `DW`, 256, data width in bits; must be a multiple of 8.
- `DEPTH`, 16, number of words; must be at least 2.
- `AW`, $clog2(DEPTH), address width.
- `BYPASS`, 1, 1 = a same-cycle write to the registered read address is forwarded into `dout`; 0 = `dout` captures the pre-write array contents.
- `CLR_ON_RESET`, 1, 1 = the clear sequence starts automatically when `rst` deasserts.
- `CLR_VAL`, {DW{1'b0}}, value written to every word by the clear sequence.
- `clk`  in  1  clock; single domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ra`  in  AW  read address.
- `re`  in  1  read enable; loads `ra` into `ra_d`.
- `ore`  in  1  output register enable; loads `dout_r` from `M[ra_d]`.
- `dout`  out  DW  registered read data.
- `dout_vld`  out  1  `dout` holds data from a legally loaded read address.
- `wa`  in  AW  write address.
- `we`  in  1  write enable.
- `wmask`  in  DW/8  byte write enables; bit i enables `di[8i+7:8i]`.
- `di`  in  DW  write data.
- `clr_req`  in  1  single-cycle pulse that starts a clear sequence.
- `busy`  out  1  clear sequence in progress.
- `pwrbus_ram_pd`  in  32  power-down bus; functionally ignored.

## Operation
- Reset values while `rst`=1: `ra_d`=0, `dout`=0, `dout_vld`=0, clear counter=0.
- Reset state of `busy`: 1 if `CLR_ON_RESET`=1, otherwise 0. Array contents are not reset.
- FSM states:
  - CLEAR (reset state when `CLR_ON_RESET`=1): writes `CLR_VAL` to `M[cnt]` each cycle and increments `cnt`. When `cnt`=DEPTH-1 is written, moves to READY and clears `cnt`.
  - READY (reset state when `CLR_ON_RESET`=0): normal operation. `clr_req`=1 moves to CLEAR next cycle, with `cnt`=0 and `dout_vld` cleared.
- During CLEAR, `we`, `re` and `clr_req` are ignored. `ore` still operates, so `dout` may show partially cleared words; `dout_vld` stays 0.
- Write (READY, `we`=1): byte i of `M[wa]` takes byte i of `di` when `wmask[i]`=1; unmasked bytes keep their value.
- Read (READY, `re`=1): `ra_d` <= `ra` and `ra_vld` <= 1. `ra_vld` is cleared by reset and on entry to CLEAR.
- Output (`ore`=1): `dout_r` <= `M[ra_d]` and `dout_vld` <= `ra_vld`. With `ore`=0, `dout` and `dout_vld` hold.
- Bypass (`BYPASS`=1, READY, `we`=1, `wa`=`ra_d`, `ore`=1): `dout_r` takes the merged word, i.e. `di` bytes where `wmask`=1 and the old array bytes elsewhere.
- Addresses ≥ DEPTH (non-power-of-2 DEPTH): writes are dropped; reads return `CLR_VAL`.

## Timing
- Read latency: `re` in cycle N, `ore` in cycle N+1, new `dout` visible after edge N+1 (2 cycles).
- A write in cycle N is visible to any read whose `ore` edge is N+1 or later.
- A write in the same cycle as `ore` to `ra_d`: with `BYPASS`=1, `dout` shows the new data; with `BYPASS`=0, it shows the old data.
- Clear takes exactly DEPTH cycles.
  - After reset release with `CLR_ON_RESET`=1, `busy` falls after DEPTH rising edges.
  - After `clr_req` in cycle N, `busy` is high from edge N through edge N+DEPTH.
- `clr_req` while `busy`=1 is ignored; the clear is not restarted.
- `rst` asserted mid-clear: everything returns to reset values immediately; the sequence restarts from address 0 after release (if `CLR_ON_RESET`=1).

## Test plan
- Clear: DEPTH=16, `CLR_ON_RESET`=1. Release reset; `busy` is 1 for exactly 16 cycles. Then reading all 16 addresses returns 0, and `dout_vld`=1 after the first read.
- Latency: write 0xA5 fill to address 3. Assert `re`/`ra`=3 in cycle N and `ore` in N+1; `dout`=0xA5… after edge N+1 and not before.
- Byte mask: word 5 = all 0x11. Write `di`=all 0xFF with `wmask`=0x…0003; reading word 5 gives bytes 0–1 = 0xFF and the rest 0x11.
- Collision: `ra_d`=7 holds 0x0. In the same cycle, `we` to address 7 with 0x1234 and `ore`=1. `BYPASS`=1 gives `dout`=0x1234; `BYPASS`=0 gives `dout`=0x0, and a following `ore` gives 0x1234.
- Clear request: mid-traffic pulse `clr_req`.
  - `busy` is high for DEPTH cycles.
  - `we`/`re` issued during the clear are ignored.
  - `dout_vld` drops to 0.
  - Every word reads back `CLR_VAL`.
- Reset mid-clear: assert `rst` at cycle 5 of the clear. `dout`=0 and `dout_vld`=0 immediately; after release the clear restarts and runs the full DEPTH cycles.
